xpb_seq_reducer: RTL

Parametrised, runtime-programmable successor to the fixed per-segment xpb lookup tables in the modular-squaring datapath. The block accepts a vector of NUM_SEG upper-bit digits, looks up each digit's precomputed 2^k·x mod N multiple from a writable table, and accumulates all lookups serially into one unreduced sum. It sits between the squarer's partial-product split and the final carry-save reduction stage. Table contents are loaded at run time, so one netlist serves any modulus.

---
 rtl/xpb_pkg.sv | 21 ++
 rtl/xpb_table.sv | 33 +++
 rtl/xpb_seq_reducer.sv | 99 +++++++++
 3 files changed

// File: rtl/xpb_pkg.sv
// Shared defaults, FSM state type and counter sizing for the xpb sequential reducer.
package xpb_pkg;

    localparam int unsigned XPB_DATA_W  = 1024;
    localparam int unsigned XPB_SEG_W   = 5;
    localparam int unsigned XPB_NUM_SEG = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } xpb_state_t;

    // Segment counter width; a single-segment build still needs one bit.
    function automatic int unsigned seg_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SEG_CNT_W = seg_cnt_w(XPB_NUM_SEG);

endpackage

// File: rtl/xpb_table.sv
// Runtime-writable xpb multiple tables, one per segment; entry 0 always reads as zero.
module xpb_table
    import xpb_pkg::*;
#(
    parameter int unsigned DATA_W  = XPB_DATA_W,
    parameter int unsigned SEG_W   = XPB_SEG_W,
    parameter int unsigned NUM_SEG = XPB_NUM_SEG,
    parameter int unsigned CNT_W   = seg_cnt_w(NUM_SEG)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_seg,
    input  logic [SEG_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CNT_W-1:0]  rd_seg,
    input  logic [SEG_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << SEG_W;

    logic [DATA_W-1:0] mem_q [NUM_SEG][DEPTH];

    // Storage is deliberately unreset; idx 0 is never stored.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_idx != '0)) begin
            mem_q[wr_seg][wr_idx] <= wr_data;
        end
    end

    assign rd_data = (rd_idx == '0) ? '0 : mem_q[rd_seg][rd_idx];

endmodule

// File: rtl/xpb_seq_reducer.sv
// Serially looks up one xpb multiple per input digit and accumulates them into an
// unreduced sum handed to the downstream carry-save reduction stage.
module xpb_seq_reducer
    import xpb_pkg::*;
#(
    parameter  int unsigned DATA_W  = XPB_DATA_W,
    parameter  int unsigned SEG_W   = XPB_SEG_W,
    parameter  int unsigned NUM_SEG = XPB_NUM_SEG,
    parameter  int unsigned ACC_W   = DATA_W + $clog2(NUM_SEG),
    localparam int unsigned CNT_W   = seg_cnt_w(NUM_SEG),
    localparam int unsigned IN_W    = NUM_SEG * SEG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tbl_wr_en,
    input  logic [CNT_W-1:0]  tbl_wr_seg,
    input  logic [SEG_W-1:0]  tbl_wr_idx,
    input  logic [DATA_W-1:0] tbl_wr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum
);

    xpb_state_t        state_q;
    logic [IN_W-1:0]   digits_q;
    logic [CNT_W-1:0]  seg_cnt_q;
    logic [ACC_W-1:0]  acc_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] rd_data;
    logic              last_seg;

    xpb_table #(
        .DATA_W  (DATA_W),
        .SEG_W   (SEG_W),
        .NUM_SEG (NUM_SEG),
        .CNT_W   (CNT_W)
    ) u_table (
        .clk     (clk),
        .wr_en   (tbl_wr_en),
        .wr_seg  (tbl_wr_seg),
        .wr_idx  (tbl_wr_idx),
        .wr_data (tbl_wr_data),
        .rd_seg  (seg_cnt_q),
        .rd_idx  (digits_q[SEG_W-1:0]),
        .rd_data (rd_data)
    );

    assign last_seg = (seg_cnt_q == CNT_W'(NUM_SEG - 1));

    // Captured digits shift down so the current digit always sits in the low bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            digits_q    <= '0;
            seg_cnt_q   <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        digits_q  <= in_data;
                        seg_cnt_q <= '0;
                        acc_q     <= '0;
                        state_q   <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q     <= acc_q + ACC_W'(rd_data);
                    digits_q  <= digits_q >> SEG_W;
                    seg_cnt_q <= seg_cnt_q + CNT_W'(1);
                    if (last_seg) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Ready is a pure decode of the state flop, held low while reset is applied.
    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;

endmodule
